mips_bus_ctrl: RTL and testbench
================================

MIPS_BUS_CTRL -- requirements
Module: mips_bus_ctrl

Interface
REQ-001 Parameter CHECK_ALIGN, default 1; 1 = misaligned half/word requests rejected, 0 = low address bits forced to alignment.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  core request strobe, sampled only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on access completion.
REQ-012 err  output  1  one-cycle pulse on a rejected misaligned request.
REQ-013 rdata  output  32  extended load result; held until the next load done.
REQ-014 address  output  32  Avalon word address (byte address with [1:0] = 00).
REQ-015 read / write  output  1 each  Avalon read and write requests.
REQ-016 waitrequest  input  1  Avalon stall.
REQ-017 writedata  output  32  lane-positioned store data.
REQ-018 byteenable  output  4  active byte lanes.
REQ-019 readdata  input  32  valid in the cycle after a read is accepted.

Function
REQ-020 FSM states are IDLE, BUS, RDATA; all outputs are registered.
REQ-021 IDLE, req=1, legal: latch request; next cycle enter BUS with read=~req_we, write=req_we, address, byteenable and writedata valid.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=00; with CHECK_ALIGN=1, err pulses next cycle, FSM stays IDLE, no bus strobe.
REQ-023 BUS: read/write and all Avalon outputs are held stable while waitrequest=1.
REQ-024 BUS: on waitrequest=0, the access is accepted; store goes to IDLE with done pulse next cycle; load goes to RDATA; the strobe drops next cycle.
REQ-025 RDATA: capture readdata, select the lane by addr[1:0], extend per req_size/req_signed into rdata, pulse done, and return to IDLE next cycle.
REQ-026 Lanes are little-endian: byte at offset k uses byteenable[k] and bits [8k+7:8k]; half uses offset 0 or 2.
REQ-027 byteenable is 0001<<off for byte, 0011<<off for half, and 1111 for word.
REQ-028 writedata carries the byte or half shifted into its lane; other lanes are don't-care but driven with replicated data.
REQ-029 Zero-wait latency: store req at cycle 0, write at cycle 1, done at cycle 2; load req at cycle 0, read at cycle 1, done and rdata at cycle 3.
REQ-030 req while busy=1 is ignored; the core must hold req until busy=0.
REQ-031 read and write are never high simultaneously.

Reset
REQ-032 reset forces IDLE; read=0, write=0, done=0, err=0, busy=0, address=0, byteenable=0, writedata=0, rdata=0.
REQ-033 reset mid-access abandons the transfer with strobes low on the next edge; no done pulse is produced.
REQ-034 reset has priority over req and waitrequest in the same cycle.

Structure
REQ-035 Package mips_bus_pkg holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-036 One combinational sub-module, mips_bus_lane, performs load lane select and extension; the FSM stays in mips_bus_ctrl.

Verification
REQ-037 Load word at 0xBFC00000, waitrequest=0, readdata=0x12345678 -> read at cycle 1, be=1111, done and rdata=0x12345678 at cycle 3.
REQ-038 Signed byte load at 0x00001003, readdata=0x80FFFFFF -> address 0x00001000, be=1000, rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Half store 0xBEEF to 0x00002002 with waitrequest high for 3 cycles -> write held 4 cycles, be=1100, writedata[31:16]=0xBEEF, one done pulse.
REQ-040 Word load at 0x00000006 -> err pulse, read never asserted, busy stays 0.
REQ-041 reset asserted during BUS with waitrequest=1 -> read=0 next cycle, state IDLE, no done pulse.
REQ-042 req pulsed while busy -> ignored; exactly one bus transfer and one done pulse.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and request-decoding helpers for the MIPS core to Avalon bus bridge.
package mips_bus_pkg;

   // Access size as seen on the core side; the reserved encoding decodes to word.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   // Bridge sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUS   = 2'b01,
      ST_RDATA = 2'b10
   } state_e;

   // Map the raw 2-bit size field onto the enum, folding the reserved code into word.
   function automatic size_e decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   // A half must sit on an even byte, a word on a multiple of four.
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Offset after forcing alignment; identical to the raw offset for legal requests.
   function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: return off;
         SZ_HALF: return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   // Little-endian byte lanes touched by the access.
   function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicating the right-aligned datum puts a copy in every lane, so the active
   // lane is correct for any offset and no shifter is needed.
   function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wd);
      case (sz)
         SZ_BYTE: return {4{wd[7:0]}};
         SZ_HALF: return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/mips_bus_lane.sv
// Load-path lane selection and sign/zero extension (purely combinational).
module mips_bus_lane
   import mips_bus_pkg::*;
(
   input  logic [31:0] readdata_i,
   input  logic [1:0]  off_i,
   input  size_e       size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane, then extend it to 32 bits.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
      byte_sel = readdata_i[7:0];
      half_sel = off_i[1] ? readdata_i[31:16] : readdata_i[15:0];
      data_o   = readdata_i;
      case (off_i)
         2'd1:    byte_sel = readdata_i[15:8];
         2'd2:    byte_sel = readdata_i[23:16];
         2'd3:    byte_sel = readdata_i[31:24];
         default: byte_sel = readdata_i[7:0];
      endcase
      case (size_i)
         SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
         default: data_o = readdata_i;
      endcase
   end

endmodule

// File: rtl/mips_bus_ctrl.sv
// Single-outstanding bridge from the MIPS core load/store port to an Avalon-MM master.
// Every output comes straight from a flop; the FSM computes next values for them.
module mips_bus_ctrl
   import mips_bus_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   state_e      state_q, state_d;

   // Request context kept for the load return path.
   logic        we_q, we_d;
   size_e       size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  off_q, off_d;

   // Registered outputs.
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] address_q, address_d;
   logic [31:0] writedata_q, writedata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  byteenable_q, byteenable_d;

   size_e       req_sz;
   logic        req_reject;
   logic [1:0]  req_off;
   logic [31:0] load_ext;

   assign req_sz     = decode_size(req_size);
   assign req_reject = CHECK_ALIGN && is_misaligned(req_sz, req_addr[1:0]);
   assign req_off    = align_off(req_sz, req_addr[1:0]);

   mips_bus_lane u_lane (
      .readdata_i (readdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .signed_i   (signed_q),
      .data_o     (load_ext)
   );

   // State register with synchronous reset taking priority over all inputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: accept legal requests in IDLE, advance on bus acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req && !req_reject) state_d = ST_BUS;
         ST_BUS:   if (!waitrequest)        state_d = we_q ? ST_IDLE : ST_RDATA;
         ST_RDATA: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic: next values for the output and context registers.
   always_comb begin
      read_d       = 1'b0;
      write_d      = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      busy_d       = (state_d != ST_IDLE);
      address_d    = address_q;
      byteenable_d = byteenable_q;
      writedata_d  = writedata_q;
      rdata_d      = rdata_q;
      we_d         = we_q;
      size_d       = size_q;
      signed_d     = signed_q;
      off_d        = off_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (req_reject) begin
                  err_d = 1'b1;
               end else begin
                  read_d       = ~req_we;
                  write_d      = req_we;
                  address_d    = {req_addr[31:2], 2'b00};
                  byteenable_d = lane_mask(req_sz, req_off);
                  writedata_d  = lane_data(req_sz, req_wdata);
                  we_d         = req_we;
                  size_d       = req_sz;
                  signed_d     = req_signed;
                  off_d        = req_off;
               end
            end
         end
         ST_BUS: begin
            if (waitrequest) begin
               // Stalled: keep the strobe up; address/lanes/data already hold.
               read_d  = read_q;
               write_d = write_q;
            end else if (we_q) begin
               done_d = 1'b1;
            end
         end
         ST_RDATA: begin
            rdata_d = load_ext;
            done_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // Output and context registers, cleared by reset so an abandoned transfer leaves nothing behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         address_q    <= '0;
         byteenable_q <= '0;
         writedata_q  <= '0;
         rdata_q      <= '0;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         signed_q     <= 1'b0;
         off_q        <= 2'b00;
      end else begin
         read_q       <= read_d;
         write_q      <= write_d;
         done_q       <= done_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         address_q    <= address_d;
         byteenable_q <= byteenable_d;
         writedata_q  <= writedata_d;
         rdata_q      <= rdata_d;
         we_q         <= we_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         off_q        <= off_d;
      end
   end

   assign read       = read_q;
   assign write      = write_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign address    = address_q;
   assign byteenable = byteenable_q;
   assign writedata  = writedata_q;
   assign rdata      = rdata_q;

endmodule

// File: tb/tb_mips_bus_ctrl.sv
// Scoreboard bench for mips_bus_ctrl: the stimulus pushes expected bus accesses and
// completion events derived from byte arithmetic; monitors compare on the DUT's pulses.
module tb_mips_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = '0;
   logic        busy, done, err, read, write;
   logic [31:0] rdata, address, writedata;
   logic [3:0]  byteenable;

   mips_bus_ctrl #(.CHECK_ALIGN(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .req_wdata   (req_wdata),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .rdata       (rdata),
      .address     (address),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] wmask;
      logic [31:0] rdword;
   } bus_exp_t;

   typedef struct {
      bit          is_err;
      bit          is_load;
      logic [31:0] rdata;
   } evt_exp_t;

   bus_exp_t    bus_q[$];
   evt_exp_t    evt_q[$];

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          req_cycle = 0;
   int          first_strobe_cyc = 0;
   int          last_done_cyc = 0;
   int          strobe_len = 0;
   int          last_strobe_len = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          accept_cnt = 0;
   int          stall_left = 0;
   bit          random_wait = 1'b0;
   bit          prev_strobe = 1'b0;
   bit          rd_pending = 1'b0;
   logic [31:0] rd_next = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nbytes_of(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Reference model: derive the expected bus access and completion from byte arithmetic.
   task automatic expect_txn(input bit we, input logic [31:0] addr, input logic [1:0] sz,
                             input bit sgn, input logic [31:0] wd, input logic [31:0] rdword);
      int          nb;
      int          off;
      logic [31:0] vmask;
      logic [31:0] v;
      bus_exp_t    b;
      evt_exp_t    e;
      nb    = nbytes_of(sz);
      off   = int'(addr % 4);
      vmask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
      if ((addr % nb) != 0) begin
         e.is_err = 1'b1; e.is_load = 1'b0; e.rdata = '0;
         evt_q.push_back(e);
         return;
      end
      b.we     = we;
      b.addr   = addr & ~32'd3;
      b.be     = 4'(((1 << nb) - 1) << off);
      b.wmask  = vmask << (8 * off);
      b.wd     = (wd & vmask) << (8 * off);
      b.rdword = rdword;
      bus_q.push_back(b);
      v = (rdword >> (8 * off)) & vmask;
      if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~vmask;
      e.is_err = 1'b0; e.is_load = !we; e.rdata = v;
      evt_q.push_back(e);
   endtask

   // Present a request for one cycle, then scramble the request fields.
   task automatic drive_req(input bit we, input logic [31:0] addr, input logic [1:0] sz,
                            input bit sgn, input logic [31:0] wd);
      req = 1'b1; req_we = we; req_addr = addr; req_size = sz; req_signed = sgn; req_wdata = wd;
      req_cycle = cyc;
      @(posedge clk); #1;
      req = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
      req_signed = 1'($urandom); req_wdata = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 64) check("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [1:0] sz,
                        input bit sgn, input logic [31:0] wd, input logic [31:0] rdword);
      expect_txn(we, addr, sz, sgn, wd, rdword);
      drive_req(we, addr, sz, sgn, wd);
      wait_idle();
   endtask

   // Avalon slave: stalls on request and returns readdata the cycle after a read is accepted.
   initial forever begin
      @(posedge clk); #1;
      if (rd_pending) begin
         readdata   = rd_next;
         rd_pending = 1'b0;
      end else begin
         readdata = $urandom;
      end
      if ((read || write) && stall_left > 0) begin
         waitrequest = 1'b1;
         stall_left--;
      end else if (random_wait) begin
         waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
         waitrequest = 1'b0;
      end
   end

   // Monitor: bus-side scoreboard plus completion-event scoreboard.
   always @(negedge clk) begin
      bus_exp_t b;
      evt_exp_t e;
      if (!reset) begin
         if (read || write) begin
            if (!prev_strobe) begin
               first_strobe_cyc = cyc;
               strobe_len = 0;
            end
            strobe_len++;
            last_strobe_len = strobe_len;
            check("rw_exclusive", 32'(read & write), 32'd0);
            if (bus_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_strobe: read=%0b write=%0b address=%h, expected no access", read, write, address);
            end else begin
               b = bus_q[0];
               check("bus_address", address, b.addr);
               check("bus_be", 32'(byteenable), 32'(b.be));
               check("bus_write", 32'(write), 32'(b.we));
               check("bus_read", 32'(read), 32'(!b.we));
               if (b.we) check("bus_wdata", writedata & b.wmask, b.wd);
               if (!waitrequest) begin
                  accept_cnt++;
                  if (!b.we) begin
                     rd_next    = b.rdword;
                     rd_pending = 1'b1;
                  end
                  b = bus_q.pop_front();
               end
            end
         end
         prev_strobe = read || write;
         if (done || err) begin
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (err) err_cnt++;
            if (evt_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_event: done=%0b err=%0b, expected none", done, err);
            end else begin
               e = evt_q.pop_front();
               check("evt_err", 32'(err), 32'(e.is_err));
               check("evt_done", 32'(done), 32'(!e.is_err));
               if (done && e.is_load) check("load_rdata", rdata, e.rdata);
            end
         end
      end else begin
         prev_strobe = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int a0;
      int e0;
      // Reset held with a request pending: reset must win.
      req = 1'b1; req_addr = 32'h0000_0004; req_size = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; req = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_read", 32'(read), 32'd0);
      check("rst_write", 32'(write), 32'd0);
      check("rst_address", address, 32'd0);
      check("rst_be", 32'(byteenable), 32'd0);
      check("rst_wdata", writedata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      idle(1);

      // Zero-wait word load: strobe at cycle 1, done and rdata at cycle 3.
      issue(1'b0, 32'hBFC0_0000, 2'b10, 1'b0, $urandom, 32'h1234_5678);
      idle(2);
      check("load_strobe_lat", 32'(first_strobe_cyc - req_cycle), 32'd1);
      check("load_done_lat", 32'(last_done_cyc - req_cycle), 32'd3);
      check("load_word", rdata, 32'h1234_5678);

      // Top-lane byte load, signed then unsigned.
      issue(1'b0, 32'h0000_1003, 2'b00, 1'b1, $urandom, 32'h80FF_FFFF);
      idle(2);
      check("lb_signed", rdata, 32'hFFFF_FF80);
      issue(1'b0, 32'h0000_1003, 2'b00, 1'b0, $urandom, 32'h80FF_FFFF);
      idle(2);
      check("lb_unsigned", rdata, 32'h0000_0080);

      // Zero-wait store: strobe at cycle 1, done at cycle 2; rdata untouched.
      issue(1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'hCAFE_F00D, 32'd0);
      idle(2);
      check("store_strobe_lat", 32'(first_strobe_cyc - req_cycle), 32'd1);
      check("store_done_lat", 32'(last_done_cyc - req_cycle), 32'd2);
      check("rdata_held", rdata, 32'h0000_0080);

      // Half store stalled three cycles.
      d0 = done_cnt;
      stall_left = 3;
      issue(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h1234_BEEF, 32'd0);
      idle(2);
      check("stall_hold_len", 32'(last_strobe_len), 32'd4);
      check("stall_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Misaligned word load: err only.
      e0 = err_cnt; a0 = accept_cnt;
      expect_txn(1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'd0, 32'd0);
      drive_req(1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'd0);
      check("misalign_busy", 32'(busy), 32'd0);
      check("misalign_err", 32'(err), 32'd1);
      idle(2);
      check("misalign_busy2", 32'(busy), 32'd0);
      check("misalign_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("misalign_no_access", 32'(accept_cnt - a0), 32'd0);

      // Reset in the middle of a stalled read.
      d0 = done_cnt;
      stall_left = 20;
      expect_txn(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'd0, 32'd0);
      drive_req(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'd0);
      check("midrst_read_pre", 32'(read), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus_q.delete();
      evt_q.delete();
      stall_left = 0;
      check("midrst_read", 32'(read), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      idle(4);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

      // Request pulsed while busy is ignored.
      d0 = done_cnt; a0 = accept_cnt;
      stall_left = 3;
      expect_txn(1'b0, 32'h0000_0300, 2'b01, 1'b1, 32'd0, 32'h0000_9ABC);
      drive_req(1'b0, 32'h0000_0300, 2'b01, 1'b1, 32'd0);
      req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0400; req_size = 2'b10;
      @(posedge clk); #1;
      req = 1'b0;
      wait_idle();
      idle(3);
      check("busy_req_accepts", 32'(accept_cnt - a0), 32'd1);
      check("busy_req_dones", 32'(done_cnt - d0), 32'd1);
      check("busy_req_rdata", rdata, 32'hFFFF_9ABC);

      // Randomized traffic with random stalls; most requests aligned, some not.
      random_wait = 1'b1;
      for (int i = 0; i < 300; i++) begin
         bit          we;
         bit          sgn;
         logic [1:0]  sz;
         logic [31:0] addr;
         we   = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes_of(sz) - 1);
         issue(we, addr, sz, sgn, $urandom, $urandom);
      end
      random_wait = 1'b0;
      idle(4);
      check("evt_q_drained", 32'(evt_q.size()), 32'd0);
      check("bus_q_drained", 32'(bus_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
